// File: rtl/ase_hssi_mon_pkg.sv
// Shared types for the ASE HSSI event monitor: event type enum and record payload.
package ase_hssi_mon_pkg;

  // Record fields are sized for the largest supported configuration; the top
  // narrows them to its parameterised port widths.
  localparam int unsigned EV_CH_W  = 4;
  localparam int unsigned EV_LEN_W = 16;
  localparam int unsigned EV_TS_W  = 64;

  typedef enum logic [1:0] {
    EV_PKT      = 2'd0,
    EV_ERR      = 2'd1,
    EV_OVERSIZE = 2'd2,
    EV_DROP     = 2'd3
  } t_ev_type;

  typedef struct packed {
    logic [EV_CH_W-1:0]  ch;
    t_ev_type            ev_type;
    logic [EV_LEN_W-1:0] len;
    logic [EV_TS_W-1:0]  ts;
  } t_hssi_ev;

  // Error outranks oversize; a clean packet is a plain EV_PKT.
  function automatic t_ev_type classify(input logic err, input logic ovs);
    t_ev_type t;
    t = EV_PKT;
    if (err) begin
      t = EV_ERR;
    end else if (ovs) begin
      t = EV_OVERSIZE;
    end
    return t;
  endfunction

endpackage

// File: rtl/ase_hssi_mon_fifo.sv
// First-word-fall-through record FIFO; head data reads as zero while empty.
module ase_hssi_mon_fifo
  import ase_hssi_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  t_hssi_ev wr_data,
  input  logic     rd_en,
  output t_hssi_ev rd_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  t_hssi_ev      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  // A write into a full FIFO is accepted when a read frees a slot the same cycle.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ase_hssi_event_monitor.sv
// Passive multi-channel HSSI stream monitor: per-channel packet measurement,
// one-entry pending slots, round-robin arbitration into a FWFT record FIFO.
module ase_hssi_event_monitor
  import ase_hssi_mon_pkg::*;
#(
  parameter  int unsigned NUM_CH        = 4,
  parameter  int unsigned MAX_PKT_BEATS = 256,
  parameter  int unsigned FIFO_DEPTH    = 16,
  parameter  int unsigned TS_W          = 32,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LEN_W         = $clog2(MAX_PKT_BEATS + 1)
) (
  input  logic              clk,
  input  logic              SoftReset,
  input  logic              mon_en,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_last,
  input  logic [NUM_CH-1:0] ch_err,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CH_W-1:0]   ev_ch,
  output logic [1:0]        ev_type,
  output logic [LEN_W-1:0]  ev_len,
  output logic [TS_W-1:0]   ev_ts,
  output logic [15:0]       drop_cnt
);

  logic [TS_W-1:0]             ts_q;
  logic [NUM_CH-1:0]           form;
  logic [NUM_CH-1:0]           drop;
  logic [NUM_CH-1:0]           pend_vld;
  logic [NUM_CH-1:0]           gnt;
  t_hssi_ev [NUM_CH-1:0]       pend_rec;
  logic [CH_W-1:0]             rr_ptr;
  logic [CH_W-1:0]             gnt_idx;
  logic                        gnt_any;
  logic                        fifo_full;
  logic                        fifo_empty;
  t_hssi_ev                    head;
  logic [4:0]                  drop_n;
  logic [16:0]                 drop_sum;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk) begin
    if (SoftReset) ts_q <= '0;
    else           ts_q <= ts_q + TS_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             in_pkt;
    logic             ign;
    logic             err_q;
    logic             ovs_q;
    logic [LEN_W-1:0] cnt_q;
    logic             beat;
    logic             track;
    logic             at_max;
    logic             err_n;
    logic             ovs_n;
    logic [LEN_W-1:0] cnt_n;
    logic             pend_vld_q;
    t_hssi_ev         pend_q;
    t_hssi_ev         new_rec;

    assign beat   = ch_valid[i] & ch_ready[i];
    // Packets that began while disabled are skipped to their last beat.
    assign track  = beat & ~ign & (in_pkt | mon_en);
    assign at_max = (cnt_q == LEN_W'(MAX_PKT_BEATS));
    assign cnt_n  = at_max ? cnt_q : cnt_q + LEN_W'(1);
    assign ovs_n  = ovs_q | at_max;
    assign err_n  = err_q | ch_err[i];
    assign form[i] = track & ch_last[i];

    always_comb begin
      new_rec         = '0;
      new_rec.ch      = EV_CH_W'(i);
      new_rec.ev_type = classify(err_n, ovs_n);
      new_rec.len     = EV_LEN_W'(cnt_n);
      new_rec.ts      = EV_TS_W'(ts_q);
    end

    always_ff @(posedge clk) begin
      if (SoftReset) begin
        in_pkt <= 1'b0;
        ign    <= 1'b0;
        cnt_q  <= '0;
        err_q  <= 1'b0;
        ovs_q  <= 1'b0;
      end else if (track) begin
        if (ch_last[i]) begin
          in_pkt <= 1'b0;
          cnt_q  <= '0;
          err_q  <= 1'b0;
          ovs_q  <= 1'b0;
        end else begin
          in_pkt <= 1'b1;
          cnt_q  <= cnt_n;
          err_q  <= err_n;
          ovs_q  <= ovs_n;
        end
      end else if (beat) begin
        ign <= ~ch_last[i];
      end
    end

    // A slot granted this cycle frees up in time to take a new record.
    always_ff @(posedge clk) begin
      if (SoftReset) begin
        pend_vld_q <= 1'b0;
        pend_q     <= '0;
      end else if (form[i] && (!pend_vld_q || gnt[i])) begin
        pend_vld_q <= 1'b1;
        pend_q     <= new_rec;
      end else if (gnt[i]) begin
        pend_vld_q <= 1'b0;
      end
    end

    assign drop[i]     = form[i] & pend_vld_q & ~gnt[i];
    assign pend_vld[i] = pend_vld_q;
    assign pend_rec[i] = pend_q;
  end

  // Round-robin: first occupied slot at or after rr_ptr, only with FIFO space.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      idx = (int'(rr_ptr) + k) % int'(NUM_CH);
      if (!gnt_any && pend_vld[CH_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    if (fifo_full) gnt_any = 1'b0;
    if (gnt_any)   gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  // Lost records accumulate by the number of colliding channels, saturating.
  always_comb begin
    drop_n = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      drop_n = drop_n + 5'(drop[k]);
    end
    drop_sum = 17'(drop_cnt) + 17'(drop_n);
  end

  always_ff @(posedge clk) begin
    if (SoftReset)                 drop_cnt <= '0;
    else if (drop_sum > 17'hFFFF)  drop_cnt <= 16'hFFFF;
    else                           drop_cnt <= drop_sum[15:0];
  end

  ase_hssi_mon_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (SoftReset),
    .wr_en   (gnt_any),
    .wr_data (pend_rec[gnt_idx]),
    .rd_en   (ev_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_ch    = CH_W'(head.ch);
  assign ev_type  = head.ev_type;
  assign ev_len   = LEN_W'(head.len);
  assign ev_ts    = TS_W'(head.ts);

endmodule
